// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial wide adder: feeds one nibble pair per clock into a 4-bit CLA slice.
// Latency: NIB clocks from the accepted start edge to the done cycle; one add per NIB+1 cycles.
// Backpressure: start is ignored while busy=1; a start during the done cycle is accepted.
// Optional macro CLA_SERIAL_OVF_EN adds a registered signed-overflow output (ovf).

// 4-bit carry-lookahead slice: all carries come from generate/propagate terms.
module cla4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] c;

  // Generate/propagate terms and lookahead carries for all four bit positions
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ {c[3], c[2], c[1], cin};
    cout = c[4];
  end

endmodule

module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BW   = $clog2(WIDTH);

  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nx;
  logic [BW-1:0]    bitpos;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_sum;
  logic             s_cout;

  // Select the current nibble pair and merge the slice result into the work value
  always_comb begin
    bitpos  = BW'({idx, 2'b00});
    a_nib   = op_a[bitpos +: 4];
    b_nib   = op_b[bitpos +: 4];
    work_nx = work;
    work_nx[bitpos +: 4] = s_sum;
  end

  cla4bit u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef CLA_SERIAL_OVF_EN
  logic msb_cin;
  // Carry into the MSB recovered from the MSB sum bit of the final nibble
  assign msb_cin = a_nib[3] ^ b_nib[3] ^ s_sum[3];
`endif

  // Sequencer: capture operands, step one nibble per clock, publish result on the last nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= in0;
            op_b  <= in1;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work  <= work_nx;
          carry <= s_cout;
          if (idx == LAST) begin
            // Result becomes visible only here, so sum/cout never show partial values
            sum   <= work_nx;
            cout  <= s_cout;
`ifdef CLA_SERIAL_OVF_EN
            ovf   <= s_cout ^ msb_cin;
`endif
            idx   <= '0;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
